ht_req_arb: RTL and testbench
=============================

// Module: ht_req_arb
// PURPOSE
//  N_CH-input round-robin arbiter merging hash-table request streams (key/value/opcode/bucket/head_ptr)
//  into one output stream, with a 2-entry registered skid buffer.
//  Sits between the per-port request front ends and the single hash-table pipeline.
//  Tags each output with the source channel index so responses can be routed back.
// PARAMETERS
//  N_CH    4   number of request channels, >=2
//  CH_W    $clog2(N_CH)   channel index width (derived, localparam)
//  CNT_W   32  width of per-channel statistics counters (HT_REQ_ARB_STATS_EN only)
// PORTS
//  clk              in   1                clock
//  rst_n            in   1                asynchronous reset, active-low
//  in_key           in   N_CH*KEY_WIDTH   per-channel key, channel i at [i*KEY_WIDTH +: KEY_WIDTH]
//  in_value         in   N_CH*VALUE_WIDTH per-channel value
//  in_opcode        in   ht_opcode_t[N_CH] per-channel opcode
//  in_bucket        in   N_CH*BUCKET_WIDTH per-channel bucket
//  in_head_ptr      in   N_CH*HEAD_PTR_WIDTH per-channel head pointer
//  in_head_ptr_val  in   N_CH             per-channel head pointer valid
//  in_valid         in   N_CH             per-channel request valid
//  in_ready         out  N_CH             per-channel accept
//  out_key/out_value/out_opcode/out_bucket/out_head_ptr/out_head_ptr_val  out  (as above, one channel)
//  out_ch           out  CH_W             source channel of out_* word
//  out_valid        out  1                output word valid
//  out_ready        in   1                downstream accept
//  stat_clr         in   1                synchronous clear of statistics counters
//  stat_cnt         out  N_CH*CNT_W       per-channel accepted-request counts
// BEHAVIOUR
//  - Transfer on input i when in_valid[i] & in_ready[i]; on output when out_valid & out_ready.
//  - Buffer: 2 entries, registered count cnt (0..2). out_* driven from head entry; out_valid = (cnt!=0).
//  - in_ready[i] = grant[i] & (cnt<2). grant depends only on in_valid and registered rr_ptr;
//    in_ready has no combinational path from out_ready.
//  - Round robin: grant = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2 ... modulo N_CH.
//    rr_ptr <= granted index only on an accepted input transfer; else holds.
//  - At most one input transfer per cycle; grant is one-hot or zero.
//  - Latency: accepted request appears on out_* the next cycle when cnt was 0.
//  - Throughput 1 word/cycle with out_ready held high.
//  - cnt==2: all in_ready=0; pop allowed. cnt==1 push+pop same cycle: cnt stays 1, order kept (FIFO).
//  - cnt==0 and no pop: out_* hold last value (don't-care, must not be X after reset).
//  - Input-side rule: source must hold in_valid and data stable until accepted; arbiter may switch
//    grant away from a waiting channel only after it is served (fairness = at most N_CH-1 waits).
//  - Reset (async assert, any time incl. mid-transfer): cnt=0, out_valid=0, all out_* data=0,
//    out_ch=0, rr_ptr=N_CH-1 (channel 0 wins first), stat_cnt=0; buffered words are dropped.
// CONFIGURATION
//  HT_REQ_ARB_STATS_EN defined: stat_cnt[i] increments on each accepted input transfer on channel i,
//   saturates at all-ones; stat_clr zeroes all counters (clear wins over same-cycle increment).
//  Not defined: counters not built; stat_cnt tied to 0, stat_clr ignored. Ports always present.
// STRUCTURE
//  - KEY_WIDTH, VALUE_WIDTH, BUCKET_WIDTH, HEAD_PTR_WIDTH, ht_opcode_t come from package hash_table.
//  - Add to hash_table: typedef struct packed ht_req_t {key,value,opcode,bucket,head_ptr,head_ptr_val}
//    used for the buffer entry and channel mux.
//  - One sub-module: ht_rr_arb #(N) (in_valid, rr_ptr -> one-hot grant + index), reusable elsewhere.
// TESTING
//  1 Reset: rst_n low mid-burst with cnt=2 -> out_valid=0, in_ready=0 during reset, stat_cnt=0;
//    after release with in_valid=4'b1111 -> channel 0 granted first.
//  2 Fairness: N_CH=4, in_valid=4'b1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0,1...,
//    one word per cycle, first word one cycle after first accept.
//  3 Backpressure: out_ready=0, ch2 sends keys 0x11,0x22,0x33 -> first two accepted, in_ready[2]=0
//    at cnt=2; out_ready=1 -> words leave in order 0x11,0x22,0x33, no loss/duplication.
//  4 Skip idle: in_valid=4'b1010 with rr_ptr=1 -> grant 3, then 1, then 3; channels 0,2 never granted.
//  5 Push+pop at cnt=1: continuous traffic with out_ready toggling 1010... -> cnt stays in 1..2,
//    scoreboard matches every field incl. head_ptr_val and out_ch.
//  6 Stats (HT_REQ_ARB_STATS_EN, CNT_W=4): 17 accepts on ch1 -> stat_cnt[1]=15 (saturated);
//    stat_clr with concurrent accept -> 0; without macro stat_cnt=0 throughout.

Source files
------------

// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - hash-table request field widths, opcode enum and request word struct
package hash_table;

   localparam int KEY_WIDTH      = 32;
   localparam int VALUE_WIDTH    = 32;
   localparam int BUCKET_WIDTH   = 10;
   localparam int HEAD_PTR_WIDTH = 16;

   typedef enum logic [1:0] {
      HT_OP_SEARCH = 2'd0,
      HT_OP_INSERT = 2'd1,
      HT_OP_DELETE = 2'd2,
      HT_OP_UPDATE = 2'd3
   } ht_opcode_t;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]      key;
      logic [VALUE_WIDTH-1:0]    value;
      ht_opcode_t                opcode;
      logic [BUCKET_WIDTH-1:0]   bucket;
      logic [HEAD_PTR_WIDTH-1:0] head_ptr;
      logic                      head_ptr_val;
   } ht_req_t;

endpackage

// File: rtl/ht_rr_arb.sv
// rtl/ht_rr_arb.sv - round-robin grant: first valid requester after rr_ptr_i, modulo N
module ht_rr_arb #(
   parameter int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid_i,
   input  logic [IW-1:0] rr_ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          grant_any_o
);

   logic [IW-1:0] cand;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      cand        = '0;
      // Walk from farthest to nearest so the nearest valid candidate wins.
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(rr_ptr_i) + k) % N);
         if (valid_i[cand]) begin
            grant_idx_o = cand;
            grant_any_o = 1'b1;
         end
      end
      if (grant_any_o) grant_o[grant_idx_o] = 1'b1;
   end

endmodule

// File: rtl/ht_req_arb.sv
// rtl/ht_req_arb.sv - N_CH-way round-robin merge of hash-table requests into a 2-entry skid buffer
// Optional per-channel accept counters under HT_REQ_ARB_STATS_EN.
module ht_req_arb
   import hash_table::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_CH*KEY_WIDTH-1:0]        in_key,
   input  logic [N_CH*VALUE_WIDTH-1:0]      in_value,
   input  ht_opcode_t [N_CH-1:0]            in_opcode,
   input  logic [N_CH*BUCKET_WIDTH-1:0]     in_bucket,
   input  logic [N_CH*HEAD_PTR_WIDTH-1:0]   in_head_ptr,
   input  logic [N_CH-1:0]                  in_head_ptr_val,
   input  logic [N_CH-1:0]                  in_valid,
   output logic [N_CH-1:0]                  in_ready,
   output logic [KEY_WIDTH-1:0]             out_key,
   output logic [VALUE_WIDTH-1:0]           out_value,
   output ht_opcode_t                       out_opcode,
   output logic [BUCKET_WIDTH-1:0]          out_bucket,
   output logic [HEAD_PTR_WIDTH-1:0]        out_head_ptr,
   output logic                             out_head_ptr_val,
   output logic [CH_W-1:0]                  out_ch,
   output logic                             out_valid,
   input  logic                             out_ready,
   input  logic                             stat_clr,
   output logic [N_CH*CNT_W-1:0]            stat_cnt
);

   logic [1:0]      cnt_q, cnt_d;
   logic [CH_W-1:0] rr_ptr_q;
   ht_req_t         head_q, head_d, tail_q, tail_d;
   logic [CH_W-1:0] hch_q, hch_d, tch_q, tch_d;
   logic [N_CH-1:0] grant;
   logic [CH_W-1:0] gidx;
   logic            gany;
   ht_req_t         sel_req;
   logic            push, pop;

   ht_rr_arb #(.N(N_CH)) u_rr (
      .valid_i     (in_valid),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (gidx),
      .grant_any_o (gany)
   );

   always_comb begin
      sel_req              = '0;
      sel_req.key          = in_key[gidx*KEY_WIDTH +: KEY_WIDTH];
      sel_req.value        = in_value[gidx*VALUE_WIDTH +: VALUE_WIDTH];
      sel_req.opcode       = in_opcode[gidx];
      sel_req.bucket       = in_bucket[gidx*BUCKET_WIDTH +: BUCKET_WIDTH];
      sel_req.head_ptr     = in_head_ptr[gidx*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH];
      sel_req.head_ptr_val = in_head_ptr_val[gidx];
   end

   // Ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = grant & {N_CH{rst_n && (cnt_q != 2'd2)}};
   assign push      = gany && (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign pop       = out_valid && out_ready;

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      hch_d  = hch_q;
      tch_d  = tch_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_d = sel_req;
               hch_d  = gidx;
            end else begin
               tail_d = sel_req;
               tch_d  = gidx;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
               hch_d  = tch_q;
            end
            cnt_d = cnt_q - 2'd1;
         end
         // Simultaneous push/pop only occurs at cnt==1: new word replaces the head.
         2'b11: begin
            head_d = sel_req;
            hch_d  = gidx;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         rr_ptr_q <= CH_W'(N_CH - 1);
         head_q   <= '0;
         tail_q   <= '0;
         hch_q    <= '0;
         tch_q    <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         hch_q  <= hch_d;
         tch_q  <= tch_d;
         if (push) rr_ptr_q <= gidx;
      end
   end

   assign out_key          = head_q.key;
   assign out_value        = head_q.value;
   assign out_opcode       = head_q.opcode;
   assign out_bucket       = head_q.bucket;
   assign out_head_ptr     = head_q.head_ptr;
   assign out_head_ptr_val = head_q.head_ptr_val;
   assign out_ch           = hch_q;

`ifdef HT_REQ_ARB_STATS_EN
   logic [CNT_W-1:0] stat_q [N_CH];

   // Clear has priority over a same-cycle accept; counts saturate at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) stat_q[i] <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < N_CH; i++) stat_q[i] <= '0;
      end else if (push && (stat_q[gidx] != '1)) begin
         stat_q[gidx] <= stat_q[gidx] + 1'b1;
      end
   end

   always_comb begin
      stat_cnt = '0;
      for (int i = 0; i < N_CH; i++) stat_cnt[i*CNT_W +: CNT_W] = stat_q[i];
   end
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_ht_req_arb.sv
// tb/tb_ht_req_arb.sv - randomized queue-model bench for ht_req_arb (HT_REQ_ARB_STATS_EN optional)
module tb_ht_req_arb;
   import hash_table::*;

   localparam int N = 4;
`ifdef HT_REQ_ARB_STATS_EN
   localparam bit STATS = 1'b1;
   localparam int CW    = 4;
`else
   localparam bit STATS = 1'b0;
   localparam int CW    = 32;
`endif
   localparam int CHW = $clog2(N);

   logic                          clk, rst_n;
   logic [N*KEY_WIDTH-1:0]        in_key;
   logic [N*VALUE_WIDTH-1:0]      in_value;
   ht_opcode_t [N-1:0]            in_opcode;
   logic [N*BUCKET_WIDTH-1:0]     in_bucket;
   logic [N*HEAD_PTR_WIDTH-1:0]   in_head_ptr;
   logic [N-1:0]                  in_head_ptr_val, in_valid, in_ready;
   logic [KEY_WIDTH-1:0]          out_key;
   logic [VALUE_WIDTH-1:0]        out_value;
   ht_opcode_t                    out_opcode;
   logic [BUCKET_WIDTH-1:0]       out_bucket;
   logic [HEAD_PTR_WIDTH-1:0]     out_head_ptr;
   logic                          out_head_ptr_val;
   logic [CHW-1:0]                out_ch;
   logic                          out_valid, out_ready, stat_clr;
   logic [N*CW-1:0]               stat_cnt;

   ht_req_arb #(.N_CH(N), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_key(in_key), .in_value(in_value), .in_opcode(in_opcode), .in_bucket(in_bucket),
      .in_head_ptr(in_head_ptr), .in_head_ptr_val(in_head_ptr_val),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_key(out_key), .out_value(out_value), .out_opcode(out_opcode), .out_bucket(out_bucket),
      .out_head_ptr(out_head_ptr), .out_head_ptr_val(out_head_ptr_val), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready),
      .stat_clr(stat_clr), .stat_cnt(stat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   // Reference model: FIFO of expected words, round-robin pointer, per-channel counts.
   ht_req_t mq[$];
   int      mch[$];
   int      rr;
   longint  scnt[N];
   int      acc[N];
   bit      pv[N];
   bit      en[N];
   ht_req_t pd[N];
   int      refill;
   logic [KEY_WIDTH-1:0] popped[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ht_req_t rand_req();
      ht_req_t r;
      r.key          = $urandom;
      r.value        = $urandom;
      r.opcode       = ht_opcode_t'(2'($urandom_range(0, 3)));
      r.bucket       = BUCKET_WIDTH'($urandom);
      r.head_ptr     = HEAD_PTR_WIDTH'($urandom);
      r.head_ptr_val = 1'($urandom_range(0, 1));
      return r;
   endfunction

   function automatic int model_grant();
      if (mq.size() >= 2) return -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (rr + k) % N;
         if (pv[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [N*CW-1:0] model_stats();
      logic [N*CW-1:0] s;
      s = '0;
      if (STATS) for (int i = 0; i < N; i++) s[i*CW +: CW] = CW'(scnt[i]);
      return s;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         in_key[i*KEY_WIDTH +: KEY_WIDTH]                = pd[i].key;
         in_value[i*VALUE_WIDTH +: VALUE_WIDTH]          = pd[i].value;
         in_opcode[i]                                    = pd[i].opcode;
         in_bucket[i*BUCKET_WIDTH +: BUCKET_WIDTH]       = pd[i].bucket;
         in_head_ptr[i*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH] = pd[i].head_ptr;
         in_head_ptr_val[i]                              = pd[i].head_ptr_val;
         in_valid[i]                                     = pv[i];
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mch.delete();
      rr = N - 1;
      for (int i = 0; i < N; i++) scnt[i] = 0;
   endtask

   task automatic cycle(input string tag);
      int g;
      logic [N-1:0] er;
      bit pop, clr;
      drive();
      @(negedge clk);
      g  = model_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk({tag, ".in_ready"}, 128'(in_ready), 128'(er));
      chk({tag, ".out_valid"}, 128'(out_valid), 128'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk({tag, ".out_word"}, 128'({out_key, out_value, out_opcode, out_bucket,
                                       out_head_ptr, out_head_ptr_val}), 128'(mq[0]));
         chk({tag, ".out_ch"}, 128'(out_ch), 128'(mch[0]));
      end
      chk({tag, ".stat_cnt"}, 128'(stat_cnt), 128'(model_stats()));
      pop = (mq.size() != 0) && out_ready;
      clr = stat_clr;
      if (pop) popped.push_back(out_key);
      @(posedge clk);
      #1;
      if (pop) begin
         void'(mq.pop_front());
         void'(mch.pop_front());
      end
      if (g >= 0) begin
         mq.push_back(pd[g]);
         mch.push_back(g);
         rr = g;
         acc[g]++;
         if (scnt[g] < (longint'(1) << CW) - 1) scnt[g]++;
         pv[g] = 1'b0;
      end
      if (clr) for (int i = 0; i < N; i++) scnt[i] = 0;
      for (int i = 0; i < N; i++)
         if (!pv[i] && en[i] && (refill == 1 || (refill == 2 && $urandom_range(0, 1) == 1))) begin
            pd[i] = rand_req();
            pv[i] = 1'b1;
         end
      drive();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [KEY_WIDTH-1:0] keys[3];
      int idx;
      keys[0] = 'h11; keys[1] = 'h22; keys[2] = 'h33;
      rst_n = 1'b0; out_ready = 1'b0; stat_clr = 1'b0; refill = 0;
      for (int i = 0; i < N; i++) begin
         pv[i] = 1'b0; en[i] = 1'b1; pd[i] = rand_req(); acc[i] = 0;
      end
      model_reset();
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst.out_word", 128'({out_key, out_value, out_opcode, out_bucket,
                                out_head_ptr, out_head_ptr_val}), 128'(0));
      chk("rst.out_ch", 128'(out_ch), 128'(0));
      cycle("idle");

      // Fill to cnt=2 then reset asynchronously mid-cycle.
      for (int i = 0; i < N; i++) begin pd[i] = rand_req(); pv[i] = 1'b1; end
      refill = 1;
      repeat (3) cycle("fill");
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid.out_valid", 128'(out_valid), 128'(0));
      chk("rst_mid.in_ready", 128'(in_ready), 128'(0));
      chk("rst_mid.stat_cnt", 128'(stat_cnt), 128'(0));
      chk("rst_mid.out_word", 128'({out_key, out_value, out_opcode, out_bucket,
                                    out_head_ptr, out_head_ptr_val}), 128'(0));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst.first_grant", 128'(in_ready), 128'(4'b0001));

      // Fairness at full rate.
      out_ready = 1'b1;
      repeat (12) cycle("fair");

      refill = 0;
      for (int i = 0; i < N; i++) pv[i] = 1'b0;
      repeat (3) cycle("drain");

      // Backpressure on channel 2 with fixed keys.
      out_ready = 1'b0;
      popped.delete();
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         if (!pv[2] && idx < 3) begin
            pd[2] = rand_req(); pd[2].key = keys[idx]; pv[2] = 1'b1; idx++;
         end
         out_ready = (c >= 4);
         cycle("bp");
      end
      chk("bp.pop_count", 128'(popped.size()), 128'(3));
      for (int i = 0; i < 3 && i < popped.size(); i++) chk("bp.order", 128'(popped[i]), 128'(keys[i]));

      // Skip idle channels: steer rr_ptr to 1, then only channels 1 and 3 request.
      out_ready = 1'b1;
      pd[1] = rand_req(); pv[1] = 1'b1;
      cycle("skip_setup");
      for (int i = 0; i < N; i++) en[i] = (i == 1 || i == 3);
      pd[1] = rand_req(); pv[1] = 1'b1;
      pd[3] = rand_req(); pv[3] = 1'b1;
      drive();
      #1;
      chk("skip.first_grant", 128'(in_ready), 128'(4'b1000));
      refill = 1;
      acc[0] = 0; acc[2] = 0;
      repeat (6) cycle("skip");
      chk("skip.ch0_untouched", 128'(acc[0]), 128'(0));
      chk("skip.ch2_untouched", 128'(acc[2]), 128'(0));

      // Random traffic with out_ready toggling 1010...
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      refill = 2;
      for (int c = 0; c < 60; c++) begin
         out_ready = (c % 2 == 0);
         cycle("rand");
      end

      refill = 0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) pv[i] = 1'b0;
      repeat (3) cycle("drain2");

      // Statistics: saturation on channel 1, then clear against concurrent accept.
      stat_clr = 1'b1;
      cycle("stat_clr0");
      stat_clr = 1'b0;
      for (int i = 0; i < N; i++) en[i] = (i == 1);
      acc[1] = 0;
      pd[1] = rand_req(); pv[1] = 1'b1;
      refill = 1;
      for (int c = 0; c < 100 && acc[1] < 17; c++) cycle("stat_run");
      chk("stat.accepts", 128'(acc[1]), 128'(17));
      chk("stat.ch1_sat", 128'(stat_cnt[1*CW +: CW]), 128'(STATS ? 15 : 0));
      stat_clr = 1'b1;
      cycle("stat_clr");
      stat_clr = 1'b0;
      chk("stat.cleared", 128'(stat_cnt), 128'(0));
      cycle("stat_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
